// File: rtl/hud_timer_drawer_if.sv
// Control, pixel-scan and draw signals between the HUD timer and its neighbours.
// master drives the controls and scan position; slave is the timer drawer itself.
interface hud_timer_drawer_if;
    logic        startGame;
    logic        pause;
    logic        oneSecPulse;
    logic        bonusAdd;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        timerDR;
    logic [7:0]  timerRGB;
    logic        timeUp;
    logic [11:0] secondsLeft;

    modport master (
        output startGame, pause, oneSecPulse, bonusAdd, pixelX, pixelY,
        input  timerDR, timerRGB, timeUp, secondsLeft
    );

    modport slave (
        input  startGame, pause, oneSecPulse, bonusAdd, pixelX, pixelY,
        output timerDR, timerRGB, timeUp, secondsLeft
    );
endinterface

// File: rtl/hud_timer_drawer.sv
// BCD countdown timer (000-999 s) that also renders its value as three
// seven-segment digits, with a registered one-cycle draw path.
module hud_timer_drawer #(
    parameter int unsigned TOPLEFT_X  = 16,
    parameter int unsigned TOPLEFT_Y  = 8,
    parameter int unsigned START_SEC  = 180,
    parameter int unsigned BONUS_SEC  = 30,
    parameter int unsigned WARN_SEC   = 10,
    parameter logic [7:0]  COLOR      = 8'hFF,
    parameter logic [7:0]  WARN_COLOR = 8'hE0
) (
    input logic               clk,
    input logic               reset,
    hud_timer_drawer_if.slave bus
);

    function automatic logic [11:0] to_bcd(input int unsigned v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Per-digit BCD add; a carry out of the hundreds digit means > 999.
    function automatic logic [11:0] bcd_add_sat(input logic [11:0] a, input logic [11:0] b);
        logic [4:0]  s;
        logic        c;
        logic [11:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (s > 5'd9) begin
                s = s - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = s[3:0];
        end
        return c ? 12'h999 : r;
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] a);
        logic [11:0] r;
        logic        borrow;
        r      = a;
        borrow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Bit order {a, b, c, d, e, f, g}.
    function automatic logic [6:0] seg_mask(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] seg_hit(input logic [3:0] lx, input logic [4:0] ly);
        logic mid_x;
        mid_x = (lx >= 4'd2) && (lx <= 4'd13);
        return {
            (ly <= 5'd3) && mid_x,
            (lx >= 4'd12) && (ly >= 5'd2) && (ly <= 5'd15),
            (lx >= 4'd12) && (ly >= 5'd16) && (ly <= 5'd29),
            (ly >= 5'd28) && mid_x,
            (lx <= 4'd3) && (ly >= 5'd16) && (ly <= 5'd29),
            (lx <= 4'd3) && (ly >= 5'd2) && (ly <= 5'd15),
            (ly >= 5'd14) && (ly <= 5'd17) && mid_x
        };
    endfunction

    localparam logic [11:0] START_BCD = to_bcd(START_SEC);
    localparam logic [11:0] BONUS_BCD = to_bcd(BONUS_SEC);
    localparam logic [11:0] WARN_BCD  = to_bcd(WARN_SEC);
    localparam logic [11:0] ORIGIN_Y  = 12'(TOPLEFT_Y);

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

    state_e      state_q;
    logic [11:0] count_q;
    logic        draw_q;
    logic [7:0]  rgb_q;
    logic        time_up_q;

    logic [11:0] bumped;
    logic [11:0] run_next;
    logic        run_expire;
    logic        lit;
    logic        warn;
    logic [11:0] px;
    logic [11:0] py;
    logic [11:0] ox;
    logic [3:0]  lx;
    logic [4:0]  ly;
    logic        in_y;

    // Tick and bonus in the same cycle: saturate first, then decrement.
    always_comb begin
        bumped     = bus.bonusAdd ? bcd_add_sat(count_q, BONUS_BCD) : count_q;
        run_next   = (bus.oneSecPulse && bumped != 12'h000) ? bcd_dec(bumped) : bumped;
        run_expire = bus.oneSecPulse && (bumped == 12'h001);
    end

    // Widened compares keep pixels left of / above the origin simply outside.
    always_comb begin
        px   = {1'b0, bus.pixelX};
        py   = {1'b0, bus.pixelY};
        in_y = (py >= ORIGIN_Y) && (py < ORIGIN_Y + 12'd32);
        ly   = 5'(py - ORIGIN_Y);
        lit  = 1'b0;
        ox   = '0;
        lx   = '0;
        for (int i = 0; i < 3; i++) begin
            ox = 12'(TOPLEFT_X + 20 * i);
            lx = 4'(px - ox);
            if (in_y && px >= ox && px < ox + 12'd16) begin
                lit = lit | (|(seg_hit(lx, ly) & seg_mask(count_q[4*(2-i) +: 4])));
            end
        end
        warn = count_q <= WARN_BCD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= START_BCD;
            draw_q    <= 1'b0;
            rgb_q     <= 8'h00;
            time_up_q <= 1'b0;
        end else begin
            time_up_q <= 1'b0;
            draw_q    <= lit;
            rgb_q     <= lit ? (warn ? WARN_COLOR : COLOR) : 8'h00;
            if (bus.startGame) begin
                count_q <= START_BCD;
                state_q <= StRun;
            end else begin
                unique case (state_q)
                    StRun: begin
                        if (bus.pause) begin
                            count_q <= bumped;
                            state_q <= StPaused;
                        end else begin
                            count_q <= run_next;
                            if (run_expire) begin
                                state_q   <= StExpired;
                                time_up_q <= 1'b1;
                            end
                        end
                    end
                    StPaused: begin
                        count_q <= bumped;
                        if (!bus.pause) state_q <= StRun;
                    end
                    StIdle, StExpired: ;
                endcase
            end
        end
    end

    assign bus.timerDR     = draw_q;
    assign bus.timerRGB    = rgb_q;
    assign bus.timeUp      = time_up_q;
    assign bus.secondsLeft = count_q;

endmodule

// File: tb/tb_hud_timer_drawer.sv
// Scoreboarded bench for hud_timer_drawer: a decimal reference model pushes the
// expected outputs per driven cycle, popped and compared after the clock edge.
module tb_hud_timer_drawer;
    localparam int TX = 16;
    localparam int TY = 8;
    localparam int START = 180;

    typedef struct packed {
        logic [11:0] cnt;
        logic        tu;
        logic        dr;
        logic [7:0]  rgb;
    } exp_t;

    typedef enum int {MIdle, MRun, MPaused, MExp} mstate_e;

    logic clk = 1'b0;
    logic reset;
    hud_timer_drawer_if bus ();

    hud_timer_drawer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_errors = 0;
    exp_t    sb[$];
    int      m_cnt;
    mstate_e m_st;

    int    seg_x0[7] = '{2, 12, 12, 2, 0, 0, 2};
    int    seg_x1[7] = '{13, 15, 15, 13, 3, 3, 13};
    int    seg_y0[7] = '{0, 2, 16, 28, 16, 2, 14};
    int    seg_y1[7] = '{3, 15, 29, 31, 29, 15, 17};
    string segs[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg"};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit lit_model(input int px, input int py, input int cnt);
        int dig[3];
        int ox;
        int lx;
        int ly;
        string s;
        dig = '{cnt / 100, (cnt / 10) % 10, cnt % 10};
        for (int i = 0; i < 3; i++) begin
            ox = TX + 20 * i;
            if (px >= ox && px < ox + 16 && py >= TY && py < TY + 32) begin
                lx = px - ox;
                ly = py - TY;
                s  = segs[dig[i]];
                for (int k = 0; k < s.len(); k++) begin
                    for (int g = 0; g < 7; g++) begin
                        if (s[k] == 8'(97 + g) && lx >= seg_x0[g] && lx <= seg_x1[g] &&
                            ly >= seg_y0[g] && ly <= seg_y1[g]) return 1'b1;
                    end
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic int sat_add(input int v);
        return (v + 30 > 999) ? 999 : v + 30;
    endfunction

    task automatic cyc(input bit rs, input bit sg, input bit ps, input bit tk, input bit bn,
                       input int px, input int py);
        exp_t e;
        reset           = rs;
        bus.startGame   = sg;
        bus.pause       = ps;
        bus.oneSecPulse = tk;
        bus.bonusAdd    = bn;
        bus.pixelX      = 11'(px);
        bus.pixelY      = 11'(py);
        e = '0;
        if (rs) begin
            m_st  = MIdle;
            m_cnt = START;
        end else begin
            if (lit_model(px, py, m_cnt)) begin
                e.dr  = 1'b1;
                e.rgb = (m_cnt <= 10) ? 8'hE0 : 8'hFF;
            end
            if (sg) begin
                m_cnt = START;
                m_st  = MRun;
            end else begin
                case (m_st)
                    MRun: begin
                        if (ps) begin
                            if (bn) m_cnt = sat_add(m_cnt);
                            m_st = MPaused;
                        end else begin
                            if (bn) m_cnt = sat_add(m_cnt);
                            if (tk && m_cnt > 0) begin
                                m_cnt--;
                                if (m_cnt == 0) begin
                                    e.tu = 1'b1;
                                    m_st = MExp;
                                end
                            end
                        end
                    end
                    MPaused: begin
                        if (bn) m_cnt = sat_add(m_cnt);
                        if (!ps) m_st = MRun;
                    end
                    default: ;
                endcase
            end
        end
        e.cnt = bcd(m_cnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("secondsLeft", 32'(bus.secondsLeft), 32'(e.cnt));
        check("timeUp", 32'(bus.timeUp), 32'(e.tu));
        check("timerDR", 32'(bus.timerDR), 32'(e.dr));
        check("timerRGB", 32'(bus.timerRGB), 32'(e.rgb));
    endtask

    task automatic step(input bit sg, input bit ps, input bit tk, input bit bn);
        cyc(1'b0, sg, ps, tk, bn, int'($urandom_range(0, 90)), int'($urandom_range(0, 45)));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic probe(input int px, input int py);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, px, py);
    endtask

    initial begin
        m_cnt = START;
        m_st  = MIdle;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("reset_count", 32'(bus.secondsLeft), 32'h180);
        check("reset_dr", 32'(bus.timerDR), 32'h0);
        check("reset_rgb", 32'(bus.timerRGB), 32'h0);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        check("after3", 32'(bus.secondsLeft), 32'h177);
        probe(TX + 5, TY + 1);
        check("one_seg_a_unlit", 32'(bus.timerDR), 32'h0);

        ticks(77);
        check("at100", 32'(bus.secondsLeft), 32'h100);
        ticks(1);
        check("borrow099", 32'(bus.secondsLeft), 32'h099);
        probe(TX + 45, TY + 15);
        check("nine_g_dr", 32'(bus.timerDR), 32'h1);
        check("nine_g_rgb", 32'(bus.timerRGB), 32'hFF);

        ticks(89);
        check("at010", 32'(bus.secondsLeft), 32'h010);
        probe(TX + 20 + 13, TY + 5);
        check("warn_dr", 32'(bus.timerDR), 32'h1);
        check("warn_rgb", 32'(bus.timerRGB), 32'hE0);
        ticks(9);
        check("at001", 32'(bus.secondsLeft), 32'h001);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("expire_cnt", 32'(bus.secondsLeft), 32'h000);
        check("expire_pulse", 32'(bus.timeUp), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("pulse_one_cycle", 32'(bus.timeUp), 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("expired_hold", 32'(bus.secondsLeft), 32'h000);
        check("expired_no_pulse", 32'(bus.timeUp), 32'h0);

        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("start_wins", 32'(bus.secondsLeft), 32'h180);
        ticks(130);
        check("at050", 32'(bus.secondsLeft), 32'h050);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        check("paused_hold", 32'(bus.secondsLeft), 32'h050);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("paused_bonus", 32'(bus.secondsLeft), 32'h080);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("resume_tick", 32'(bus.secondsLeft), 32'h079);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 27; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("at990", 32'(bus.secondsLeft), 32'h990);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("sat_then_dec", 32'(bus.secondsLeft), 32'h998);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat999", 32'(bus.secondsLeft), 32'h999);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(138);
        check("at042", 32'(bus.secondsLeft), 32'h042);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, TX + 5, TY + 16);
        check("midrun_reset", 32'(bus.secondsLeft), 32'h180);
        check("midrun_reset_dr", 32'(bus.timerDR), 32'h0);
        ticks(3);
        check("idle_hold", 32'(bus.secondsLeft), 32'h180);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hud_timer_drawer.md
Name: hud_timer_drawer

Overview:
- Game countdown timer that also draws its value on screen: three 7-segment-style decimal digits (seconds, 000–999).
- Produces the timer draw request and colour pair consumed by the HUD metadata multiplexer.
- Also flags timer expiry to the game controller.
- Sits in the Meta Data group, fed by the VGA pixel scan coordinates and the one-second tick generator.

Parameters:
- TOPLEFT_X, 16, screen X of the left edge of digit 0 (hundreds).
- TOPLEFT_Y, 8, screen Y of the top edge of all digits.
- START_SEC, 180, value loaded on reset/start; must be ≤ 999.
- BONUS_SEC, 30, seconds added per bonusAdd pulse.
- WARN_SEC, 10, at or below this value digits use WARN_COLOR.
- COLOR, 8'hFF, normal digit colour (RGB332).
- WARN_COLOR, 8'hE0, warning digit colour.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- startGame  input  1  one-cycle pulse: reload START_SEC and begin counting.
- pause  input  1  level: while high, ticks are ignored.
- oneSecPulse  input  1  one-cycle pulse once per second.
- bonusAdd  input  1  one-cycle pulse: add BONUS_SEC.
- pixelX  input  11  current scan X.
- pixelY  input  11  current scan Y.
- timerDR  output  1  draw request for the current pixel (registered).
- timerRGB  output  8  colour for the current pixel (registered).
- timeUp  output  1  one-cycle pulse when the count reaches 0.
- secondsLeft  output  12  current count as 3 BCD digits {hundreds, tens, units}.

Behaviour:
- Reset (synchronous, highest priority): state=IDLE; count=START_SEC in BCD; timerDR=0, timerRGB=0, timeUp=0.
- States: IDLE, RUN, PAUSED, EXPIRED.
  - IDLE: count held; digits are still drawn.
  - startGame (any state) → count=START_SEC, next state RUN.
  - RUN: pause=1 → PAUSED next cycle. oneSecPulse with pause=0 → decrement.
  - PAUSED: pause=0 → RUN. Ticks are ignored in PAUSED.
  - Decrement from 001 → count=000, state EXPIRED, timeUp=1 for exactly that one cycle.
  - EXPIRED: count held at 000; ticks and bonusAdd are ignored; only startGame or reset leaves.
- Arithmetic is BCD:
  - Decrement borrows across digits (100→099, 010→009).
  - bonusAdd is accepted in RUN and PAUSED only. It adds BONUS_SEC with BCD carry and saturates at 999.
  - Same-cycle tick and bonusAdd in RUN: result = saturate(count + BONUS_SEC) − 1. Count never expires that cycle.
  - startGame in the same cycle as a tick or bonus: startGame wins.
- Geometry:
  - Digit i (0=hundreds) occupies a 16x32 cell. Origin X = TOPLEFT_X + 20*i, Y = TOPLEFT_Y (4-px gap between digits).
  - Local coordinates lx, ly. Pixels outside all three cells are not drawn.
- Segments (inclusive ranges):
  - a: ly 0–3, lx 2–13
  - b: lx 12–15, ly 2–15
  - c: lx 12–15, ly 16–29
  - d: ly 28–31, lx 2–13
  - e: lx 0–3, ly 16–29
  - f: lx 0–3, ly 2–15
  - g: ly 14–17, lx 2–13
- Standard decimal segment sets; 7 uses a, b, c.
- Leading zeros are drawn.
- Draw output, one-cycle latency: timerDR/timerRGB reflect the pixelX/pixelY of the previous cycle.
  - Lit pixel: timerDR=1; timerRGB=WARN_COLOR if count ≤ WARN_SEC, else COLOR.
  - Unlit pixel: timerDR=0, timerRGB=8'h00.
- Colour and digit selection use the count as registered in the same cycle the pixel is sampled.
- Coordinate compare must not underflow: pixelX < TOPLEFT_X is simply "outside".

Test Plan:
- Reset, then startGame. Issue 3 oneSecPulse → secondsLeft=12'h177. Pixel (TOPLEFT_X+5, TOPLEFT_Y+1), segment a of '1' is unlit → timerDR=0 one cycle later.
- Load via reset with START_SEC=100, startGame, 1 tick → 12'h099. Probe pixel (TOPLEFT_X+45, TOPLEFT_Y+15), segment g of '9' → timerDR=1, timerRGB=8'hFF.
- Count down to 10 → probe any lit pixel → timerRGB=8'hE0. At 001 + tick → secondsLeft=000 and timeUp high exactly 1 cycle. Further ticks and bonusAdd leave the count at 000 with no further timeUp.
- Hold pause=1 across 5 ticks → count unchanged. bonusAdd while PAUSED at 12'h050 → 12'h080. Release pause, 1 tick → 12'h079.
- At 12'h990: bonusAdd and oneSecPulse in the same cycle → 12'h998 (saturate to 999, then −1). Bonus alone at 999 → stays 999.
- Mid-RUN reset at 12'h042 → next cycle IDLE, 12'h180, timerDR=0. Ticks in IDLE → no change.
